mem_wb_register: RTL and testbench
==================================

MEM_WB_REGISTER -- requirements
Module: mem_wb_register

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of datapath words (ALU result, memory data, PC+4, write-back data).
REQ-002 SHALL have parameter CNT_W, default 32, width of retire counter.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold all stage state this cycle.
REQ-006 SHALL have port flush  input  1  replace captured instruction with a bubble.
REQ-007 SHALL have port mem_valid  input  1  MEM stage holds a real instruction.
REQ-008 SHALL have port mem_reg_write  input  1  instruction writes a register.
REQ-009 SHALL have port mem_mem_to_reg  input  1  write-back source is memory read data.
REQ-010 SHALL have port mem_link  input  1  write-back source is PC+4 (jal); overrides mem_mem_to_reg.
REQ-011 SHALL have port mem_alu_result  input  DATA_W  ALU result from MEM stage.
REQ-012 SHALL have port mem_read_data  input  DATA_W  data-memory read data.
REQ-013 SHALL have port mem_pc_plus4  input  DATA_W  link address.
REQ-014 SHALL have port mem_dst  input  5  destination register number.
REQ-015 SHALL have port wb_valid  output  1  WB stage holds a real instruction.
REQ-016 SHALL have port wb_reg_write  output  1  register-file write enable.
REQ-017 SHALL have port wb_dst  output  5  write-back destination; consumed by forwarding comparator.
REQ-018 SHALL have port wb_data  output  DATA_W  write-back value.
REQ-019 SHALL have port retire_count  output  CNT_W  count of valid instructions entering WB.
REQ-020 Clock port SHALL be named clk and reset port reset; one clock; reset synchronous, active-high.

Function
REQ-021 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-022 Per-edge priority SHALL be: reset > flush > stall > load.
REQ-023 Load (no reset/flush/stall): wb_valid <= mem_valid; wb_dst <= mem_valid ? mem_dst : 0.
REQ-024 Load: wb_reg_write <= mem_valid & mem_reg_write & (mem_dst != 0); register $0 never written.
REQ-025 Load: wb_data <= mem_link ? mem_pc_plus4 : mem_mem_to_reg ? mem_read_data : mem_alu_result; selection made before the register, 1-cycle latency.
REQ-026 Load with mem_valid=0: wb_data <= 0, wb_reg_write <= 0.
REQ-027 Stall: every output, including retire_count, SHALL hold its previous value.
REQ-028 Flush (regardless of stall): wb_valid, wb_reg_write, wb_dst, wb_data <= 0; retire_count holds.
REQ-029 retire_count SHALL increment by 1 on each load edge with mem_valid=1; wraps from 2^CNT_W-1 to 0 silently.
REQ-030 A bubble (wb_valid=0) SHALL always present wb_dst=0 and wb_reg_write=0 so downstream comparators see no live write.
REQ-031 Back-to-back loads SHALL sustain one instruction per cycle with no dead cycles.

Reset
REQ-032 On reset edge all outputs SHALL be 0, including retire_count, irrespective of stall/flush.
REQ-033 Reset asserted mid-stall SHALL discard held instruction; first edge after reset deasserts SHALL perform a normal load.
REQ-034 No initial-block values SHALL be relied on; state is defined only after first reset edge.

Verification
REQ-035 Load ALU op: mem_valid=1, reg_write=1, dst=8, alu=0x1234 -> next edge wb_valid=1, wb_reg_write=1, wb_dst=8, wb_data=0x1234, retire_count=1.
REQ-036 Source select: mem_to_reg=1, read_data=0xDEAD -> wb_data=0xDEAD; additionally mem_link=1, pc_plus4=0x40 -> wb_data=0x40.
REQ-037 $0 suppression: dst=0, reg_write=1, valid=1 -> wb_reg_write=0, wb_dst=0, wb_valid=1, retire_count increments.
REQ-038 Stall 3 cycles while inputs change -> outputs and retire_count unchanged across all 3 edges; fourth edge loads current inputs.
REQ-039 flush=1 and stall=1 same edge with valid instruction present -> bubble (all zero except retire_count held).
REQ-040 Preload retire_count to 2^CNT_W-1 via loads (CNT_W=4 instance: 15 loads) -> next valid load gives 0; reset mid-stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register.
// Captures the instruction leaving the MEM stage, selects its write-back
// value ahead of the register, and counts retired instructions. Bubbles
// always present dst=0 and reg_write=0, so forwarding comparators
// downstream never see a live write from an empty slot.
module mem_wb_register #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic              mem_link,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] mem_pc_plus4,
  input  logic [4:0]        mem_dst,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_count
);

  logic              r_wb_valid;
  logic              r_wb_reg_write;
  logic [4:0]        r_wb_dst;
  logic [DATA_W-1:0] r_wb_data;
  logic [CNT_W-1:0]  r_retire_count;

  logic              w_reg_write_nxt;
  logic [4:0]        w_dst_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  // Link (PC+4) takes precedence over memory data, which takes precedence
  // over the ALU result.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic              link,
    input logic              mem_to_reg,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] rdata,
    input logic [DATA_W-1:0] pc4
  );
    if (link)            return pc4;
    else if (mem_to_reg) return rdata;
    else                 return alu;
  endfunction

  // Next-stage values for a load; an invalid slot collapses to all zeros
  // and a write to $0 is suppressed.
  always_comb begin
    w_reg_write_nxt = 1'b0;
    w_dst_nxt       = 5'd0;
    w_data_nxt      = '0;
    if (mem_valid) begin
      w_reg_write_nxt = mem_reg_write & (mem_dst != 5'd0);
      w_dst_nxt       = mem_dst;
      w_data_nxt      = wb_select(mem_link, mem_mem_to_reg, mem_alu_result,
                                  mem_read_data, mem_pc_plus4);
    end
  end

  // Stage register: reset > flush > stall > load. Flush leaves the retire
  // count untouched since the squashed slot never retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_dst       <= 5'd0;
      r_wb_data      <= '0;
      r_retire_count <= '0;
    end else if (flush) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_dst       <= 5'd0;
      r_wb_data      <= '0;
    end else if (!stall) begin
      r_wb_valid     <= mem_valid;
      r_wb_reg_write <= w_reg_write_nxt;
      r_wb_dst       <= w_dst_nxt;
      r_wb_data      <= w_data_nxt;
      if (mem_valid) begin
        r_retire_count <= r_retire_count + CNT_W'(1);
      end
    end
  end

  assign wb_valid     = r_wb_valid;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_dst       = r_wb_dst;
  assign wb_data      = r_wb_data;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_mem_wb_register.sv
// Testbench for mem_wb_register (DATA_W=32, CNT_W=4 so the counter wraps).
module tb_mem_wb_register;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset, stall, flush;
  logic              mem_valid, mem_reg_write, mem_mem_to_reg, mem_link;
  logic [DATA_W-1:0] mem_alu_result, mem_read_data, mem_pc_plus4;
  logic [4:0]        mem_dst;
  logic              wb_valid, wb_reg_write;
  logic [4:0]        wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  retire_count;

  mem_wb_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_link(mem_link),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .mem_pc_plus4(mem_pc_plus4), .mem_dst(mem_dst),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
    .wb_data(wb_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              v;
    logic              rw;
    logic [4:0]        dst;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;  // reference state of the WB stage
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the WB state, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic stl, input logic fl,
                      input logic v, input logic rw, input logic m2r, input logic lnk,
                      input logic [31:0] alu, input logic [31:0] rd,
                      input logic [31:0] pc4, input logic [4:0] dst);
    exp_t e;
    reset = rst; stall = stl; flush = fl;
    mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r; mem_link = lnk;
    mem_alu_result = alu; mem_read_data = rd; mem_pc_plus4 = pc4; mem_dst = dst;
    if (rst) begin
      m.v = 0; m.rw = 0; m.dst = 0; m.data = 0; m.cnt = 0;
    end else if (fl) begin
      m.v = 0; m.rw = 0; m.dst = 0; m.data = 0;
    end else if (!stl) begin
      m.v    = v;
      m.dst  = v ? dst : 5'd0;
      m.rw   = v && rw && (dst != 5'd0);
      m.data = !v ? 32'd0 : lnk ? pc4 : m2r ? rd : alu;
      if (v) m.cnt = m.cnt + 4'd1;
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".valid"}, 32'(wb_valid), 32'(e.v));
    check({tag, ".rw"},    32'(wb_reg_write), 32'(e.rw));
    check({tag, ".dst"},   32'(wb_dst), 32'(e.dst));
    check({tag, ".data"},  wb_data, e.data);
    check({tag, ".cnt"},   32'(retire_count), 32'(e.cnt));
  endtask

  initial begin
    m = '{v: 0, rw: 0, dst: 0, data: 0, cnt: 0};
    step("reset", 1, 0, 0, 1, 1, 0, 0, 32'h55, 32'h66, 32'h77, 5'd3);
    check("reset_cnt_zero", 32'(retire_count), 32'd0);
    // ALU load
    step("alu", 0, 0, 0, 1, 1, 0, 0, 32'h1234, 32'h0, 32'h0, 5'd8);
    check("alu_data_literal", wb_data, 32'h1234);
    check("alu_cnt_literal", 32'(retire_count), 32'd1);
    // Source select
    step("mem2reg", 0, 0, 0, 1, 1, 1, 0, 32'h1111, 32'hDEAD, 32'h40, 5'd9);
    check("mem2reg_literal", wb_data, 32'hDEAD);
    step("link", 0, 0, 0, 1, 1, 1, 1, 32'h1111, 32'hDEAD, 32'h40, 5'd31);
    check("link_literal", wb_data, 32'h40);
    // $0 suppression
    step("r0", 0, 0, 0, 1, 1, 0, 0, 32'hABCD, 32'h0, 32'h0, 5'd0);
    check("r0_rw_literal", 32'(wb_reg_write), 32'd0);
    // Invalid slot
    step("bubble_in", 0, 0, 0, 0, 1, 1, 1, 32'hFFFF, 32'hEEEE, 32'hDDDD, 5'd7);
    // Stall three cycles with changing inputs, then load
    step("stall1", 0, 1, 0, 1, 1, 0, 0, 32'hA1, 32'h0, 32'h0, 5'd1);
    step("stall2", 0, 1, 0, 0, 0, 1, 0, 32'hA2, 32'hB2, 32'h0, 5'd2);
    step("stall3", 0, 1, 0, 1, 1, 0, 1, 32'hA3, 32'h0, 32'hC3, 5'd3);
    step("unstall", 0, 0, 0, 1, 1, 0, 0, 32'hA4, 32'h0, 32'h0, 5'd4);
    check("unstall_literal", wb_data, 32'hA4);
    // Flush with stall and a valid instruction present
    step("flush_stall", 0, 1, 1, 1, 1, 0, 0, 32'h99, 32'h0, 32'h0, 5'd5);
    // Counter wrap: reset, 15 loads, then one more
    step("wrap_rst", 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 15; i++)
      step("fill", 0, 0, 0, 1, 1, 0, 0, 32'(i), 32'h0, 32'h0, 5'(i + 1));
    check("cnt_max_literal", 32'(retire_count), 32'd15);
    step("wrap", 0, 0, 0, 1, 1, 0, 0, 32'h77, 32'h0, 32'h0, 5'd6);
    check("cnt_wrap_literal", 32'(retire_count), 32'd0);
    // Reset mid-stall, then a normal load
    step("pre_stall", 0, 0, 0, 1, 1, 0, 0, 32'h5A, 32'h0, 32'h0, 5'd10);
    step("hold", 0, 1, 0, 1, 1, 0, 0, 32'h5B, 32'h0, 32'h0, 5'd11);
    step("rst_in_stall", 1, 1, 0, 1, 1, 0, 0, 32'h5C, 32'h0, 32'h0, 5'd12);
    check("rst_in_stall_literal", 32'(wb_valid), 32'd0);
    step("post_rst", 0, 0, 0, 1, 1, 0, 0, 32'h5D, 32'h0, 32'h0, 5'd13);
    // Randomised traffic
    for (int i = 0; i < 60; i++)
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
